// File: rtl/nv_nvdla_bdma_intr_drain.sv
// ---------------------------------------------------------------------------
// nv_nvdla_bdma_intr_drain
//
// Read side of the BDMA store interrupt FIFO. Each popped entry carries a
// group id (0/1); it is turned into a single-cycle done-interrupt pulse to
// GLB and recorded in sticky per-group status flags and saturating counters
// for CSB. After every pulse the block waits PULSE_GAP idle cycles before it
// pops again, so back-to-back completions never merge at GLB.
//
// Ports
//   nvdla_core_clk         in   core clock
//   nvdla_core_rstn        in   async active-low reset
//   fifo_intr_rd_pvld      in   FIFO entry valid
//   fifo_intr_rd_pd        in   FIFO entry payload (group id)
//   fifo_intr_rd_prdy      out  pop strobe to FIFO (IDLE only)
//   intr_mask[1:0]         in   per-group mask, suppresses the GLB pulse only
//   status_clr[1:0]        in   write-1-to-clear pulse for status/counter
//   bdma2glb_done_intr_pd  out  one-hot done pulse, 1 cycle wide
//   done_status[1:0]       out  sticky per-group done flags
//   done_cnt0 / done_cnt1  out  saturating completion counters per group
//   intr_idle              out  FSM idle and no entry pending
// ---------------------------------------------------------------------------
module nv_nvdla_bdma_intr_drain #(
   parameter int CNT_W     = 4,
   parameter int PULSE_GAP = 2
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             fifo_intr_rd_pvld,
   input  logic             fifo_intr_rd_pd,
   output logic             fifo_intr_rd_prdy,
   input  logic [1:0]       intr_mask,
   input  logic [1:0]       status_clr,
   output logic [1:0]       bdma2glb_done_intr_pd,
   output logic [1:0]       done_status,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1,
   output logic             intr_idle
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam logic [3:0]       GAP_LOAD = (PULSE_GAP > 0) ? 4'(PULSE_GAP - 1) : 4'd0;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_e                  state_q, state_d;
   logic                    grp_q, grp_d;
   logic [3:0]              gap_q, gap_d;
   logic [1:0]              pd_q, pd_d;
   logic [1:0]              status_q, status_d;
   logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;

   logic                    fire;
   logic [1:0]              fire_hit;

   // ---------------- state register ----------------
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q  <= ST_IDLE;
         grp_q    <= 1'b0;
         gap_q    <= 4'd0;
         pd_q     <= 2'b00;
         status_q <= 2'b00;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grp_q    <= grp_d;
         gap_q    <= gap_d;
         pd_q     <= pd_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      gap_d   = gap_q;
      unique case (state_q)
         ST_IDLE: begin
            // payload is only captured on a real handshake, so pd is don't-care otherwise
            if (fifo_intr_rd_pvld && fifo_intr_rd_prdy) begin
               grp_d   = fifo_intr_rd_pd;
               state_d = ST_FIRE;
            end
         end
         ST_FIRE: begin
            if (PULSE_GAP > 0) begin
               gap_d   = GAP_LOAD;
               state_d = ST_GAP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_q == 4'd0) state_d = ST_IDLE;
            else               gap_d   = gap_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // prdy depends on state (and reset) only; there is no pvld->prdy path.
   always_comb begin
      fifo_intr_rd_prdy = 1'b0;
      fire              = 1'b0;
      unique case (state_q)
         ST_IDLE: fifo_intr_rd_prdy = nvdla_core_rstn;
         ST_FIRE: fire              = 1'b1;
         default: ;
      endcase
   end

   assign fire_hit = fire ? (grp_q ? 2'b10 : 2'b01) : 2'b00;

   // Pulse is registered: mask sampled during FIRE, pulse visible the cycle after.
   assign pd_d = fire_hit & ~intr_mask;

   // Per-group status/counter. A completion in the same cycle as a clear wins,
   // leaving the group showing exactly that one completion.
   always_comb begin
      status_d = status_q;
      cnt_d    = cnt_q;
      for (int g = 0; g < 2; g++) begin
         if (fire_hit[g]) begin
            status_d[g] = 1'b1;
            if (status_clr[g])            cnt_d[g] = CNT_W'(1);
            else if (cnt_q[g] != CNT_MAX) cnt_d[g] = cnt_q[g] + CNT_W'(1);
         end else if (status_clr[g]) begin
            status_d[g] = 1'b0;
            cnt_d[g]    = '0;
         end
      end
   end

   assign bdma2glb_done_intr_pd = pd_q;
   assign done_status           = status_q;
   assign done_cnt0             = cnt_q[0];
   assign done_cnt1             = cnt_q[1];
   assign intr_idle             = (state_q == ST_IDLE) && !fifo_intr_rd_pvld;

endmodule

// File: tb/tb_nv_nvdla_bdma_intr_drain.sv
module tb_nv_nvdla_bdma_intr_drain;

   localparam int CNT_W     = 4;
   localparam int PULSE_GAP = 2;
   localparam int CMAX      = (1 << CNT_W) - 1;

   logic             clk;
   logic             rstn;
   logic             pvld;
   logic             pd;
   logic             prdy;
   logic [1:0]       mask;
   logic [1:0]       clr;
   logic [1:0]       intr_pd;
   logic [1:0]       status;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
   logic             idle;

   int errors = 0;
   int checks = 0;

   nv_nvdla_bdma_intr_drain #(.CNT_W(CNT_W), .PULSE_GAP(PULSE_GAP)) dut (
      .nvdla_core_clk        (clk),
      .nvdla_core_rstn       (rstn),
      .fifo_intr_rd_pvld     (pvld),
      .fifo_intr_rd_pd       (pd),
      .fifo_intr_rd_prdy     (prdy),
      .intr_mask             (mask),
      .status_clr            (clr),
      .bdma2glb_done_intr_pd (intr_pd),
      .done_status           (status),
      .done_cnt0             (cnt0),
      .done_cnt1             (cnt1),
      .intr_idle             (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Works in terms of cycle numbers: an entry popped in cycle c fires in c+1,
   // its pulse/status/count show in c+2, and the next pop may happen in
   // c+2+PULSE_GAP.
   int         cyc      = 0;
   int         next_pop = 0;
   int         fire_cyc = -1;
   int         fire_g   = 0;
   logic [1:0] m_pd     = 2'b00;
   logic [1:0] m_st     = 2'b00;
   int         m_cnt [2] = '{0, 0};

   always @(negedge clk) begin
      if (!rstn) begin
         chk("rst_prdy",   int'(prdy),    0);
         chk("rst_pd",     int'(intr_pd), 0);
         chk("rst_status", int'(status),  0);
         chk("rst_cnt0",   int'(cnt0),    0);
         chk("rst_cnt1",   int'(cnt1),    0);
         chk("rst_idle",   int'(idle),    int'(!pvld));
         m_pd     = 2'b00;
         m_st     = 2'b00;
         m_cnt    = '{0, 0};
         fire_cyc = -1;
         next_pop = cyc + 1;
      end else begin
         logic       can_pop;
         logic [1:0] new_pd;
         can_pop = (cyc >= next_pop);
         chk("prdy",   int'(prdy),    int'(can_pop));
         chk("pd",     int'(intr_pd), int'(m_pd));
         chk("status", int'(status),  int'(m_st));
         chk("cnt0",   int'(cnt0),    m_cnt[0]);
         chk("cnt1",   int'(cnt1),    m_cnt[1]);
         chk("idle",   int'(idle),    int'(can_pop && !pvld));
         new_pd = 2'b00;
         for (int g = 0; g < 2; g++) begin
            if (fire_cyc == cyc && fire_g == g) begin
               new_pd[g] = ~mask[g];
               m_st[g]   = 1'b1;
               m_cnt[g]  = clr[g] ? 1 : ((m_cnt[g] < CMAX) ? m_cnt[g] + 1 : CMAX);
            end else if (clr[g]) begin
               m_st[g]  = 1'b0;
               m_cnt[g] = 0;
            end
         end
         m_pd = new_pd;
         if (can_pop && pvld) begin
            fire_cyc = cyc + 1;
            fire_g   = int'(pd);
            next_pop = cyc + 2 + PULSE_GAP;
         end
      end
      cyc++;
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int npulse;

   initial begin
      rstn = 1'b0;
      pvld = 1'b0;
      pd   = 1'b0;
      mask = 2'b00;
      clr  = 2'b00;
      repeat (3) step();
      rstn = 1'b1;
      @(negedge clk);
      chk("lit_reset_prdy",   int'(prdy),    1);
      chk("lit_reset_pd",     int'(intr_pd), 0);
      chk("lit_reset_status", int'(status),  0);
      chk("lit_reset_idle",   int'(idle),    1);

      // single pop on group 1
      step();
      pvld = 1'b1; pd = 1'b1;
      step();
      pvld = 1'b0; pd = 1'b0;
      @(negedge clk);
      chk("lit_single_n1_pd", int'(intr_pd), 0);
      step();
      @(negedge clk);
      chk("lit_single_n2_pd",   int'(intr_pd), 2);
      chk("lit_single_status",  int'(status),  2);
      chk("lit_single_cnt1",    int'(cnt1),    1);
      step();
      @(negedge clk);
      chk("lit_single_n3_pd", int'(intr_pd), 0);

      // pvld held high on group 0: one pop every 4 cycles
      step();
      pvld = 1'b1; pd = 1'b0;
      npulse = 0;
      repeat (16) begin
         @(negedge clk);
         if (intr_pd == 2'b01) npulse++;
         step();
      end
      pvld = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (intr_pd == 2'b01) npulse++;
         step();
      end
      chk("lit_stream_pulses", npulse,     4);
      chk("lit_stream_cnt0",   int'(cnt0), 4);

      // saturation then clear
      pvld = 1'b1; pd = 1'b0;
      repeat (80) step();
      pvld = 1'b0;
      repeat (6) step();
      chk("lit_sat_cnt0", int'(cnt0), 15);
      clr = 2'b01;
      step();
      clr = 2'b00;
      @(negedge clk);
      chk("lit_clr_cnt0",   int'(cnt0),   0);
      chk("lit_clr_status", int'(status), 2);
      chk("lit_clr_cnt1",   int'(cnt1),   1);

      // second group-1 completion, then clear colliding with FIRE on group 1
      step();
      pvld = 1'b1; pd = 1'b1;
      step();
      pvld = 1'b0;
      repeat (6) step();
      chk("lit_pre_coll_cnt1", int'(cnt1), 2);
      pvld = 1'b1; pd = 1'b1;
      step();
      pvld = 1'b0; clr = 2'b10;
      step();
      clr = 2'b00;
      @(negedge clk);
      chk("lit_coll_status1", int'(status[1]), 1);
      chk("lit_coll_cnt1",    int'(cnt1),      1);

      // masked pop on group 0, then reset during GAP
      repeat (4) step();
      mask = 2'b11; pvld = 1'b1; pd = 1'b0;
      step();
      pvld = 1'b0;
      step();
      @(negedge clk);
      chk("lit_mask_pd",     int'(intr_pd), 0);
      chk("lit_mask_status", int'(status),  3);
      chk("lit_mask_cnt0",   int'(cnt0),    1);
      #1 rstn = 1'b0;
      #1;
      chk("lit_gaprst_pd",     int'(intr_pd), 0);
      chk("lit_gaprst_status", int'(status),  0);
      chk("lit_gaprst_cnt0",   int'(cnt0),    0);
      chk("lit_gaprst_cnt1",   int'(cnt1),    0);
      chk("lit_gaprst_prdy",   int'(prdy),    0);
      step();
      step();
      rstn = 1'b1; mask = 2'b00;
      @(negedge clk);
      chk("lit_after_rst_prdy", int'(prdy), 1);

      // mixed vectors, checked by the model every cycle
      repeat (60) begin
         step();
         pvld = 1'($urandom_range(0, 1));
         pd   = 1'($urandom_range(0, 1));
         mask = 2'($urandom_range(0, 3));
         clr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      step();
      pvld = 1'b0; clr = 2'b00; mask = 2'b00;
      repeat (8) step();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
